// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO.
// The head entry is always visible on rd_data while the FIFO holds data.
// rd_data is forced to zero while empty, so stale storage is never exposed.
// Status flags are derived from the registered count only.
// Overflow and underflow are sticky error flags.
module sync_fifo_fwft #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       rd_en,
    input  logic                       clr_err,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int ADDR_W = $clog2(DEPTH);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_THRESH);
    localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_THRESH);

    // Storage is intentionally left without a reset.
    logic [DATA_W-1:0] mem [DEPTH];

    // Pointers carry one extra wrap bit, so they count modulo 2*DEPTH.
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic [ADDR_W:0]   count_q;

    logic              wr_acc;
    logic              rd_acc;
    logic              ovf_set;
    logic              unf_set;

    // Status flags are decoded purely from registered state.
    // The same-cycle request inputs do not feed into them.
    always_comb begin
        full         = (count_q == DEPTH_C);
        empty        = (count_q == '0);
        almost_full  = (count_q >= AF_C);
        almost_empty = (count_q <= AE_C);
        count        = count_q;
    end

    // Accept/reject decisions.
    // Writes are refused only when full; reads are refused only when empty.
    always_comb begin
        wr_acc  = wr_en && !full;
        rd_acc  = rd_en && !empty;
        ovf_set = wr_en && full;
        unf_set = rd_en && empty;
    end

    // Head of queue falls through combinationally.
    // The output is masked to zero while the FIFO is empty.
    always_comb begin
        rd_data = '0;
        if (!empty)
            rd_data = mem[rd_ptr[ADDR_W-1:0]];
    end

    // Storage write port.
    // It is gated by rst so that a reset cycle never lands data.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc)
            mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
    end

    // Pointer and occupancy bookkeeping.
    // A simultaneous accepted read and write leaves the count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_acc)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc)
                rd_ptr <= rd_ptr + 1'b1;
            case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky error flags.
    // A new error event wins over clr_err in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= ovf_set | (overflow  & ~clr_err);
            underflow <= unf_set | (underflow & ~clr_err);
        end
    end

endmodule
